// File: rtl/pps_tick_counter.sv
// pps_tick_counter: counts fabric clk periods between accepted 1PPS edges and tracks PPS lock.
// Optional build macro PPS_DEGLITCH_EN adds a high-level run-length filter on the synchronised pin.
module pps_tick_counter #(
    parameter int unsigned CLK_FREQ_HZ      = 100000000,
    parameter int unsigned MIN_PERIOD_TICKS = 50000000,
`ifdef PPS_DEGLITCH_EN
    parameter int unsigned DEGLITCH_CYCLES  = 16,
`endif
    parameter int unsigned TIMEOUT_TICKS    = 200000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Pps,
    input  logic        PPSCountReset,
    output logic        PPSDetected,
    output logic        PpsStrobe,
    output logic [31:0] IdealTicksPerSecond,
    output logic [31:0] ActualTicksLastSecond,
    output logic [31:0] ClockTicksThisSecond,
    output logic        o_dbg_state
);

    typedef enum logic {
        NO_PPS = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_s1;
    logic        r_s2;
    logic        w_edge;
    logic [31:0] r_count;
    logic [31:0] r_actual;
    logic        r_strobe;
    logic [31:0] w_c_inc;
    logic        w_first;
    logic        w_accept;
    logic        w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= Pps;
            r_s2 <= r_s1;
        end
    end

`ifdef PPS_DEGLITCH_EN
    // Run length saturates at DEGLITCH_CYCLES so the match fires once per high level.
    logic [4:0] r_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 5'd0;
        end else if (!r_s2) begin
            r_run <= 5'd0;
        end else if (r_run != 5'(DEGLITCH_CYCLES)) begin
            r_run <= r_run + 5'd1;
        end
    end

    assign w_edge = r_s2 && (r_run == 5'(DEGLITCH_CYCLES - 1));
`else
    logic r_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p <= 1'b0;
        end else begin
            r_p <= r_s2;
        end
    end

    assign w_edge = r_s2 && !r_p;
`endif

    // Saturating count-plus-one: the interval this cycle closes if an edge is accepted.
    assign w_c_inc   = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
    assign w_first   = (r_state == NO_PPS);
    assign w_accept  = w_edge && (w_first || (w_c_inc >= MIN_PERIOD_TICKS));
    assign w_timeout = (w_c_inc >= TIMEOUT_TICKS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= NO_PPS;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            NO_PPS: begin
                if (w_accept && !PPSCountReset) begin
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (PPSCountReset || (w_timeout && !w_accept)) begin
                    w_state_next = NO_PPS;
                end
            end
            default: w_state_next = NO_PPS;
        endcase
    end

    // The register-space clear wins over an edge landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 32'd0;
            r_actual <= 32'd0;
            r_strobe <= 1'b0;
        end else if (PPSCountReset) begin
            r_count  <= 32'd0;
            r_actual <= 32'd0;
            r_strobe <= 1'b0;
        end else if (w_accept) begin
            r_count  <= 32'd0;
            r_strobe <= 1'b1;
            if (r_state == LOCKED) begin
                r_actual <= w_c_inc;
            end
        end else begin
            r_count  <= w_c_inc;
            r_strobe <= 1'b0;
        end
    end

    assign IdealTicksPerSecond   = 32'(CLK_FREQ_HZ);
    assign ActualTicksLastSecond = r_actual;
    assign ClockTicksThisSecond  = r_count;
    assign PpsStrobe             = r_strobe;
    assign PPSDetected           = (r_state == LOCKED);
    assign o_dbg_state           = r_state;

endmodule
